// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage.
// Covers load/store funct3 encodings, the access FSM states and the W bundle.
package mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
        logic        misalign;
        logic        bus_err;
    } m_w_t;

endpackage

// File: rtl/flopr.sv
// Resettable register with a synchronous active-high reset.
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/memory_access_stage_load_store_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = 8'(rdata >> {off, 3'b000});
    assign half_lane = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be       = 4'b0000;
        wdata    = store_data;
        misalign = 1'b0;
        // Only the size bits matter for steering; the sign bit is load-only.
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be       = 4'b0011 << {off[1], 1'b0};
                wdata    = {2{store_data[15:0]}};
                misalign = off[0];
            end
            2'b10: begin
                be       = 4'b1111;
                misalign = (off != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  load_data = {24'h0, byte_lane};
            F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  load_data = {16'h0, half_lane};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline M stage: data-memory handshake, stall control and M/W register.
module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RdM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic        MisalignW,
    output logic        BusErrW
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mem_state_t  state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic        mem_op, misalign, complete, abort;
    logic [31:0] load_data;
    m_w_t        w_d, w_q;

    assign mem_op   = MemWriteM || (ResultSrcM == RESULT_LOAD);
    assign mem_we   = MemWriteM;
    assign mem_addr = {ALUResultM[31:2], 2'b00};

    load_store_align u_align (
        .funct3     (Funct3M),
        .off        (ALUResultM[1:0]),
        .store_data (WriteDataM),
        .rdata      (mem_rdata),
        .be         (mem_be),
        .wdata      (mem_wdata),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_req    = 1'b0;
        StallM     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (mem_op && !misalign) begin
                        mem_req = 1'b1;
                        if (mem_ack) begin
                            complete = 1'b1;
                        end else begin
                            StallM     = 1'b1;
                            state_next = WAIT;
                            cnt_next   = CW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req    = 1'b1;
                        complete   = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        abort      = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        mem_req  = 1'b1;
                        StallM   = 1'b1;
                        cnt_next = cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // Anything that is neither a result nor an error is a bubble.
    always_comb begin
        w_d = '0;
        if (complete || (!mem_op && state == IDLE)) begin
            w_d.reg_write  = RegWriteM;
            w_d.result_src = ResultSrcM;
            w_d.rd         = RdM;
            w_d.alu_result = ALUResultM;
            w_d.read_data  = load_data;
            w_d.pc_plus4   = PCPlus4M;
        end else if (mem_op && misalign && state == IDLE) begin
            w_d.misalign = 1'b1;
        end else if (abort) begin
            w_d.bus_err = 1'b1;
        end
    end

    flopr #(.WIDTH($bits(m_w_t))) u_w_reg (
        .clk   (clk),
        .reset (reset),
        .d     (w_d),
        .q     (w_q)
    );

    assign RegWriteW  = w_q.reg_write;
    assign ResultSrcW = w_q.result_src;
    assign RdW        = w_q.rd;
    assign ALUResultW = w_q.alu_result;
    assign ReadDataW  = w_q.read_data;
    assign PCPlus4W   = w_q.pc_plus4;
    assign MisalignW  = w_q.misalign;
    assign BusErrW    = w_q.bus_err;

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory (M) stage of the five-stage pipelined RISC-V CPU. It consumes the execute stage's M-side outputs (ALUResultM, WriteDataM, RdM, PCPlus4M, control), performs byte/half/word loads and stores over a variable-latency data-memory handshake, and stalls the pipeline while memory is busy. It registers everything into the writeback (W) stage, with bubbles inserted during stalls.

## Interface
- TIMEOUT, default 16: maximum WAIT-state cycles without mem_ack before the access is aborted.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- RegWriteM, MemWriteM  in  1  control from E/M register
- ResultSrcM  in  2  2'b01 = load; other values = non-load
- Funct3M  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- RdM  in  5  destination register
- ALUResultM, WriteDataM, PCPlus4M  in  32  address / store data / link value
- mem_req  out  1  access request, level
- mem_we  out  1  1 = store
- mem_addr  out  32  {ALUResultM[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  access complete this cycle
- mem_rdata  in  32  read word, valid when mem_ack=1
- StallM  out  1  to hazard unit; freezes F/D/E/M registers
- RegWriteW  out  1
- ResultSrcW  out  2
- RdW  out  5
- ALUResultW, ReadDataW, PCPlus4W  out  32
- MisalignW, BusErrW  out  1  one-cycle error flags

## Operation
- A memory op exists when MemWriteM=1 (store) or ResultSrcM=2'b01 (load).
- Offset off = ALUResultM[1:0].
- Misaligned: h/hu with off[0]=1; w with off≠0. A misaligned op issues no mem_req and causes no stall. It writes a bubble to W with MisalignW=1.
- Store byte enables:
  - sb: mem_be = 4'b0001<<off; mem_wdata = byte replicated x4.
  - sh: mem_be = 4'b0011<<(2*off[1]); mem_wdata = half replicated x2.
  - sw: mem_be = 4'b1111.
- Loads drive mem_be the same way as stores.
- Load formatting:
  - b/bu: select byte lane off.
  - h/hu: select half lane off[1].
  - b/h sign-extend; bu/hu zero-extend.
- FSM states: IDLE and WAIT.
  - IDLE with an aligned op: mem_req=1 combinationally. If mem_ack=1, the op completes and StallM=0. Otherwise go to WAIT with StallM=1 and cnt=1.
  - WAIT: mem_req=1 and StallM=1, with the same addr/be/wdata (upstream is frozen).
    - mem_ack=1: complete, StallM=0, go to IDLE.
    - cnt==TIMEOUT without ack: abort, mem_req=0, StallM=0, bubble to W with BusErrW=1, go to IDLE.
    - Otherwise cnt++.
- W register load rules:
  - Completion or non-memory op: load RegWriteM/ResultSrcM/RdM/ALUResultM/PCPlus4M and the formatted ReadData.
  - Stall cycles, misalign, abort: load a bubble (RegWriteW=0, RdW=0, ResultSrcW=0, data 0).
- mem_ack arriving in IDLE with no request is ignored.

## Timing
- Reset values: all W outputs 0, MisalignW=0, BusErrW=0, state IDLE, cnt 0.
- mem_req=0, StallM=0 while reset=1.
- Reset in WAIT abandons the access; the next cycle is IDLE.
- Zero-wait access: 1 cycle in M; W valid at the next edge.
- N-cycle ack latency: StallM high for N cycles; W receives N bubbles, then the result.
- Timeout: StallM high for TIMEOUT cycles. The abort cycle has StallM=0, and BusErrW=1 in W the following cycle.
- Error flags last exactly one cycle unless back-to-back errors occur.

## Structure
- Package mem_stage_pkg contains:
  - funct3 constants (F3_LB … F3_LHU)
  - mem_state_t enum {IDLE, WAIT}
  - RESULT_LOAD = 2'b01
- Sub-module load_store_align: purely combinational. It takes funct3, off, store data and rdata, and produces mem_be, mem_wdata, formatted load data and misalign.
- W-stage registers use the existing flopr.

## Test plan
- sw, addr 0x100, data 0xDEADBEEF, mem_ack same cycle -> mem_be=1111, StallM never 1, RegWriteW=0 next cycle.
- lb, addr 0x103, mem_rdata 0x80112233, immediate ack -> ReadDataW=0xFFFFFF80; lbu -> 0x00000080.
- lhu, addr 0x22, ack after 3 cycles, rdata 0xBEEF0000 -> StallM high 3 cycles, 3 bubbles, then ReadDataW=0x0000BEEF, RegWriteW=1.
- lw, addr 0x40, no ack, TIMEOUT=4 -> StallM high 4 cycles, mem_req drops, BusErrW=1 for one cycle, RegWriteW=0.
- lh, addr 0x101 -> mem_req never asserts, MisalignW=1 for one cycle, no stall.
- reset asserted during WAIT (cycle 2 of stall) -> mem_req=0 and StallM=0 that cycle, all W outputs 0, next sw completes normally.
